raster_pixel_source: RTL and testbench

- Reads one stored image frame from a synchronous-read pixel memory in raster order.
- Emits it as a serial pixel stream (pixel_out + write strobe), the exact input protocol of the window line buffers that feed the Sobel and threshold stages.
- Optionally appends FLUSH_PIXELS zero pixels after the frame so downstream buffers drain.
- Supports a downstream stall, uses a one-entry skid register, and reports completion with a done pulse.

---
 rtl/raster_pixel_source.sv | 148 ++++++++++++++
 tb/tb_raster_pixel_source.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/raster_pixel_source.sv
// Raster-order frame reader: streams a stored frame as a serial pixel
// stream with stall handling, one-entry skid, optional zero flush.
module raster_pixel_source #(
  parameter int IMAGE_WIDTH  = 506,
  parameter int IMAGE_HEIGHT = 506,
  parameter int DATA_WIDTH   = 11,
  parameter int ADDR_WIDTH   = 18,
  parameter int FLUSH_PIXELS = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  write,
  output logic                  busy,
  output logic                  done
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW   = ADDR_WIDTH + 1;
  localparam int FW   = (FLUSH_PIXELS > 1) ? $clog2(FLUSH_PIXELS) : 1;

  localparam logic [CW-1:0] END_ADDR = CW'(NPIX);
  localparam logic [FW-1:0] FLUSH_LAST =
    FW'((FLUSH_PIXELS > 0) ? FLUSH_PIXELS - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         addr_cnt;
  logic [FW-1:0]         flush_cnt;
  logic                  inflight;
  logic                  skid_full;
  logic [DATA_WIDTH-1:0] skid_data;

  logic in_fetch;
  logic issue;
  logic emit_skid;
  logic emit_mem;
  logic emit_flush;
  logic capture;
  logic last_img;
  logic last_flush;

  assign in_fetch = (state == S_FETCH);

  // A read in flight plus a stall lands in the skid, so never
  // launch another read in that cycle.
  assign issue = in_fetch
              && (addr_cnt < END_ADDR)
              && !skid_full
              && !(inflight && stall);

  assign emit_skid  = skid_full && !stall;
  assign emit_mem   = inflight && !skid_full && !stall;
  assign capture    = inflight && !skid_full && stall;
  assign emit_flush = (state == S_FLUSH) && !stall;

  // Skid and an in-flight read never coexist, so the final
  // image write is any write once every address was issued.
  assign last_img   = in_fetch
                   && (emit_skid || emit_mem)
                   && (addr_cnt == END_ADDR);
  assign last_flush = emit_flush && (flush_cnt == FLUSH_LAST);

  assign mem_rd   = issue;
  assign mem_addr = addr_cnt[ADDR_WIDTH-1:0];
  assign write    = emit_skid || emit_mem || emit_flush;
  assign busy     = in_fetch || (state == S_FLUSH);
  assign done     = (state == S_DONE);

  always_comb begin
    pixel_out = '0;
    unique case (1'b1)
      emit_skid: pixel_out = skid_data;
      emit_mem:  pixel_out = mem_data;
      default:   pixel_out = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (last_img) begin
          if (FLUSH_PIXELS > 0) state_nxt = S_FLUSH;
          else                  state_nxt = S_DONE;
        end
      end
      S_FLUSH: begin
        if (last_flush) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= '0;
      flush_cnt <= '0;
      inflight  <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (state == S_IDLE) begin
      inflight  <= 1'b0;
      skid_full <= 1'b0;
      if (start) begin
        addr_cnt  <= '0;
        flush_cnt <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) addr_cnt <= addr_cnt + 1'b1;
      if (emit_flush) flush_cnt <= flush_cnt + 1'b1;
      if (capture) begin
        skid_full <= 1'b1;
        skid_data <= mem_data;
      end else if (emit_skid) begin
        skid_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_raster_pixel_source.sv
// Bench for raster_pixel_source: scoreboard of expected pixels, two DUTs
// (no flush / 5-pixel flush) fed from one frame memory.
module tb_raster_pixel_source;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int DW = 11;
  localparam int AW = 4;
  localparam int F1 = 5;

  typedef logic [DW-1:0] pix_q_t[$];

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic stall;

  logic          mem_rd    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_data  [2];
  logic [DW-1:0] pixel_out [2];
  logic          write     [2];
  logic          busy      [2];
  logic          done      [2];

  logic [DW-1:0] mem [1<<AW];
  pix_q_t        expq [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wcnt  [2];
  int dones [2];
  int base  [2];
  int lastw [2];
  logic [DW-1:0] e;

  always #5 clk = ~clk;

  raster_pixel_source #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .FLUSH_PIXELS(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]),
    .mem_data(mem_data[0]), .pixel_out(pixel_out[0]),
    .write(write[0]), .busy(busy[0]), .done(done[0])
  );

  raster_pixel_source #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .FLUSH_PIXELS(F1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]),
    .mem_data(mem_data[1]), .pixel_out(pixel_out[1]),
    .write(write[1]), .busy(busy[1]), .done(done[1])
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd[0]) mem_data[0] <= mem[mem_addr[0]];
    if (mem_rd[1]) mem_data[1] <= mem[mem_addr[1]];
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, req);
    end
  endtask

  // Scoreboard monitor: every write pops the next expected pixel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (write[d]) begin
          chk($sformatf("wr_while_stall%0d", d), int'(stall), 0);
          if (expq[d].size() == 0) begin
            chk($sformatf("unexpected_wr%0d", d), 1, 0);
          end else begin
            e = expq[d].pop_front();
            chk($sformatf("pix%0d", d), int'(pixel_out[d]), int'(e));
          end
          wcnt[d]++;
          lastw[d] = cyc;
        end
        if (done[d]) begin
          chk($sformatf("done_lag%0d", d), cyc - lastw[d], 1);
          chk($sformatf("wr_count%0d", d), wcnt[d], N + (d == 1 ? F1 : 0));
          chk($sformatf("q_left%0d", d), expq[d].size(), 0);
          chk($sformatf("busy_at_done%0d", d), int'(busy[d]), 0);
          wcnt[d] = 0;
          dones[d]++;
        end
      end
    end
  end

  // Reference: a frame is the memory image in raster order, then zeros.
  task automatic start_frame();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) expq[d].push_back(mem[i]);
      if (d == 1) for (int i = 0; i < F1; i++) expq[d].push_back('0);
      base[d] = dones[d];
    end
    @(posedge clk) #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  // Called in cycle 1 after start was sampled.
  task automatic check_timing();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk("t_rd", int'(mem_rd[0]), int'(k <= N));
      if (k <= N) chk("t_addr", int'(mem_addr[0]), k - 1);
      chk("t_wr", int'(write[0]), int'(k >= 2 && k <= N + 1));
      chk("t_busy", int'(busy[0]), int'(k <= N + 1));
      chk("t_done", int'(done[0]), int'(k == N + 2));
    end
  endtask

  task automatic wait_done(input int stall_pct);
    int i;
    i = 0;
    while ((dones[0] == base[0] || dones[1] == base[1]) && i < 600) begin
      stall = ($urandom_range(0, 99) < stall_pct);
      @(posedge clk) #1;
      i++;
    end
    stall = 1'b0;
    chk("done_timeout", int'(i >= 600), 0);
  endtask

  initial begin
    start = 1'b0;
    stall = 1'b0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wcnt[d]  = 0;
      dones[d] = 0;
      base[d]  = 0;
      lastw[d] = -10;
    end
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        chk("idle_outs",
            int'({write[d], mem_rd[d], busy[d], done[d]}), 0);
    end
    @(posedge clk) #1;

    start_frame();
    check_timing();
    wait_done(0);

    // Stalls on cycles 3, 4, 9; start re-pulsed mid-frame.
    start_frame();
    for (int k = 1; k <= 20; k++) begin
      stall = (k == 3 || k == 4 || k == 9);
      start = (k == 6);
      @(posedge clk) #1;
    end
    stall = 1'b0;
    start = 1'b0;
    wait_done(0);

    start_frame();
    check_timing();
    wait_done(0);

    repeat (4) begin
      for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 2047));
      start_frame();
      wait_done(40);
    end

    // Asynchronous reset in cycle 6 of a frame.
    start_frame();
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_outs",
          int'({write[d], mem_rd[d], busy[d], done[d]}), 0);
      chk("rst_pix", int'(pixel_out[d]), 0);
      chk("rst_addr", int'(mem_addr[d]), 0);
      expq[d].delete();
      wcnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst", int'({busy[0], done[0], busy[1], done[1]}), 0);
    end
    @(posedge clk) #1;
    start_frame();
    check_timing();
    wait_done(0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
